// File: rtl/bbox_msg_engine_if.sv
// Pixel-stream observation and message word stream bundled for bbox_msg_engine.
// The engine connects through the slave modport; the environment uses master.
interface bbox_msg_engine_if #(
   parameter int unsigned CLASS_W = 3
);
   logic               px_valid;
   logic               px_sop;
   logic               px_eop;
   logic               px_video;
   logic [CLASS_W-1:0] px_class;
   logic [31:0]        msg_data;
   logic               msg_valid;
   logic               msg_ready;
   logic               msg_last;
   logic               overrun;

   modport slave (
      input  px_valid, px_sop, px_eop, px_video, px_class, msg_ready,
      output msg_data, msg_valid, msg_last, overrun
   );

   modport master (
      output px_valid, px_sop, px_eop, px_video, px_class, msg_ready,
      input  msg_data, msg_valid, msg_last, overrun
   );
endinterface

// File: rtl/bbox_msg_engine.sv
// Per-class bounding-box tracker over the classified pixel stream with periodic message bursts.
// Optional macro BBOX_PIXCOUNT_EN adds a per-class pixel-count word after each BR word.
module bbox_msg_engine #(
   parameter int unsigned IMAGE_W      = 640,
   parameter int unsigned IMAGE_H      = 480,
   parameter int unsigned NUM_CLASSES  = 5,
   parameter int unsigned CLASS_W      = 3,
   parameter int unsigned MSG_INTERVAL = 6
) (
   input  logic             clk,
   input  logic             reset,
   bbox_msg_engine_if.slave bus
);
   localparam int unsigned CRD_W = 11;
   localparam int unsigned PIX_W = $clog2(IMAGE_W * IMAGE_H + 1) + 1;
   localparam int unsigned FC_W  = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;
   localparam int unsigned CI_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
`ifdef BBOX_PIXCOUNT_EN
   localparam int unsigned CNT_W = 20;
`endif
   localparam logic [CRD_W-1:0] X_LAST    = CRD_W'(IMAGE_W - 1);
   localparam logic [CRD_W-1:0] Y_LAST    = CRD_W'(IMAGE_H - 1);
   localparam logic [CI_W-1:0]  CLS_LAST  = CI_W'(NUM_CLASSES - 1);
   localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(MSG_INTERVAL - 1);
   localparam logic [PIX_W-1:0] PIX_FRAME = PIX_W'(IMAGE_W * IMAGE_H);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_TL,
`ifdef BBOX_PIXCOUNT_EN
      ST_CNT,
`endif
      ST_BR
   } state_t;

   logic [CRD_W-1:0] x_q, y_q;
   logic [PIX_W-1:0] pix_total_q;
   logic             video_q, eop_q, start_q, overrun_q, shd_err_q;
   logic [FC_W-1:0]  fcnt_q;
   state_t           state_q;
   logic [CI_W-1:0]  cls_q;
   logic [31:0]      msg_data_q;
   logic             msg_valid_q, msg_last_q;

   logic [CRD_W-1:0] acc_xmin_q [NUM_CLASSES];
   logic [CRD_W-1:0] acc_xmax_q [NUM_CLASSES];
   logic [CRD_W-1:0] acc_ymin_q [NUM_CLASSES];
   logic [CRD_W-1:0] acc_ymax_q [NUM_CLASSES];
   logic [CRD_W-1:0] shd_xmin_q [NUM_CLASSES];
   logic [CRD_W-1:0] shd_xmax_q [NUM_CLASSES];
   logic [CRD_W-1:0] shd_ymin_q [NUM_CLASSES];
   logic [CRD_W-1:0] shd_ymax_q [NUM_CLASSES];
`ifdef BBOX_PIXCOUNT_EN
   logic [CNT_W-1:0] acc_cnt_q  [NUM_CLASSES];
   logic [CNT_W-1:0] shd_cnt_q  [NUM_CLASSES];
`endif

   logic px_beat_c, busy_c;
   assign px_beat_c = bus.px_valid & ~bus.px_sop & video_q;
   assign busy_c    = (state_q != ST_IDLE) | start_q;

   function automatic logic [31:0] hdr_word(input logic [CI_W-1:0] c);
      logic found;
      found = (shd_xmin_q[c] <= shd_xmax_q[c]);
      return {8'h42, 8'(c) + 8'd1, 14'b0, shd_err_q, found};
   endfunction

   function automatic logic [31:0] tl_word(input logic [CI_W-1:0] c);
      return {5'b0, shd_xmin_q[c], 5'b0, shd_ymin_q[c]};
   endfunction

   function automatic logic [31:0] br_word(input logic [CI_W-1:0] c);
      return {5'b0, shd_xmax_q[c], 5'b0, shd_ymax_q[c]};
   endfunction

`ifdef BBOX_PIXCOUNT_EN
   function automatic logic [31:0] cnt_word(input logic [CI_W-1:0] c);
      return {12'b0, shd_cnt_q[c]};
   endfunction
`endif

   // Pixel position tracking and per-class accumulation; a sop beat restarts the frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q         <= '0;
         y_q         <= '0;
         pix_total_q <= '0;
         video_q     <= 1'b0;
         eop_q       <= 1'b0;
         for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_xmin_q[c] <= X_LAST;
            acc_ymin_q[c] <= Y_LAST;
            acc_xmax_q[c] <= '0;
            acc_ymax_q[c] <= '0;
`ifdef BBOX_PIXCOUNT_EN
            acc_cnt_q[c]  <= '0;
`endif
         end
      end else begin
         eop_q <= px_beat_c & bus.px_eop;
         if (bus.px_valid & bus.px_sop) begin
            video_q     <= bus.px_video;
            x_q         <= '0;
            y_q         <= '0;
            pix_total_q <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
               acc_xmin_q[c] <= X_LAST;
               acc_ymin_q[c] <= Y_LAST;
               acc_xmax_q[c] <= '0;
               acc_ymax_q[c] <= '0;
`ifdef BBOX_PIXCOUNT_EN
               acc_cnt_q[c]  <= '0;
`endif
            end
         end else if (px_beat_c) begin
            pix_total_q <= pix_total_q + 1'b1;
            if (x_q == X_LAST) begin
               x_q <= '0;
               y_q <= y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
               if (bus.px_class == CLASS_W'(c + 1)) begin
                  if (x_q < acc_xmin_q[c]) acc_xmin_q[c] <= x_q;
                  if (x_q > acc_xmax_q[c]) acc_xmax_q[c] <= x_q;
                  if (y_q < acc_ymin_q[c]) acc_ymin_q[c] <= y_q;
                  if (y_q > acc_ymax_q[c]) acc_ymax_q[c] <= y_q;
`ifdef BBOX_PIXCOUNT_EN
                  if (acc_cnt_q[c] != '1) acc_cnt_q[c] <= acc_cnt_q[c] + 1'b1;
`endif
               end
            end
         end
      end
   end

   // Frame-end snapshot, burst scheduling and the word emitter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            shd_xmin_q[c] <= X_LAST;
            shd_ymin_q[c] <= Y_LAST;
            shd_xmax_q[c] <= '0;
            shd_ymax_q[c] <= '0;
`ifdef BBOX_PIXCOUNT_EN
            shd_cnt_q[c]  <= '0;
`endif
         end
         shd_err_q   <= 1'b0;
         fcnt_q      <= FC_RELOAD;
         start_q     <= 1'b0;
         overrun_q   <= 1'b0;
         state_q     <= ST_IDLE;
         cls_q       <= '0;
         msg_data_q  <= '0;
         msg_valid_q <= 1'b0;
         msg_last_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         // eop_q lags the last pixel so the accumulators already include it here
         if (eop_q) begin
            if (!busy_c) begin
               shd_xmin_q <= acc_xmin_q;
               shd_xmax_q <= acc_xmax_q;
               shd_ymin_q <= acc_ymin_q;
               shd_ymax_q <= acc_ymax_q;
`ifdef BBOX_PIXCOUNT_EN
               shd_cnt_q  <= acc_cnt_q;
`endif
               shd_err_q  <= (pix_total_q != PIX_FRAME);
               if (fcnt_q == '0) begin
                  start_q <= 1'b1;
                  fcnt_q  <= FC_RELOAD;
               end else begin
                  fcnt_q <= fcnt_q - 1'b1;
               end
            end else if (fcnt_q == '0) begin
               overrun_q <= 1'b1;
            end else begin
               fcnt_q <= fcnt_q - 1'b1;
            end
         end

         if (start_q) begin
            state_q     <= ST_HDR;
            cls_q       <= '0;
            msg_valid_q <= 1'b1;
            msg_last_q  <= 1'b0;
            msg_data_q  <= hdr_word('0);
         end else if (msg_valid_q & bus.msg_ready) begin
            case (state_q)
               ST_HDR: begin
                  state_q    <= ST_TL;
                  msg_data_q <= tl_word(cls_q);
                  msg_last_q <= 1'b0;
               end
               ST_TL: begin
                  state_q    <= ST_BR;
                  msg_data_q <= br_word(cls_q);
`ifdef BBOX_PIXCOUNT_EN
                  msg_last_q <= 1'b0;
`else
                  msg_last_q <= (cls_q == CLS_LAST);
`endif
               end
               ST_BR: begin
`ifdef BBOX_PIXCOUNT_EN
                  state_q    <= ST_CNT;
                  msg_data_q <= cnt_word(cls_q);
                  msg_last_q <= (cls_q == CLS_LAST);
               end
               ST_CNT: begin
`endif
                  if (cls_q == CLS_LAST) begin
                     state_q     <= ST_IDLE;
                     msg_valid_q <= 1'b0;
                     msg_last_q  <= 1'b0;
                     msg_data_q  <= '0;
                  end else begin
                     state_q    <= ST_HDR;
                     cls_q      <= cls_q + 1'b1;
                     msg_data_q <= hdr_word(cls_q + 1'b1);
                     msg_last_q <= 1'b0;
                  end
               end
               default: begin
                  state_q     <= ST_IDLE;
                  msg_valid_q <= 1'b0;
                  msg_last_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.msg_data  = msg_data_q;
   assign bus.msg_valid = msg_valid_q;
   assign bus.msg_last  = msg_last_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_bbox_msg_engine.sv
// Self-checking bench for bbox_msg_engine: two instances (interval 1 and 6) on a shared pixel stream.
// Expected bursts come from a frame-image model; BBOX_PIXCOUNT_EN selects the 4-word layout.
module tb_bbox_msg_engine;
   localparam int unsigned W     = 32;
   localparam int unsigned H     = 16;
   localparam int unsigned N     = 5;
   localparam int unsigned CW    = 3;
   localparam int unsigned NPIX  = W * H;
`ifdef BBOX_PIXCOUNT_EN
   localparam int unsigned BW    = 4;
`else
   localparam int unsigned BW    = 3;
`endif
   localparam int unsigned BURST = N * BW;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          px_valid = 1'b0, px_sop = 1'b0, px_eop = 1'b0, px_video = 1'b0;
   logic [CW-1:0] px_class = '0;
   logic          rdy_a = 1'b1, rdy_b = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] img [NPIX];
   word_t         qa[$], qb[$], exp_q[$], exp1[$];

   always #5 clk = ~clk;

   bbox_msg_engine_if #(.CLASS_W(CW)) ifa ();
   bbox_msg_engine_if #(.CLASS_W(CW)) ifb ();

   assign ifa.px_valid = px_valid;
   assign ifa.px_sop = px_sop;
   assign ifa.px_eop = px_eop;
   assign ifa.px_video = px_video;
   assign ifa.px_class = px_class;
   assign ifa.msg_ready = rdy_a;
   assign ifb.px_valid = px_valid;
   assign ifb.px_sop = px_sop;
   assign ifb.px_eop = px_eop;
   assign ifb.px_video = px_video;
   assign ifb.px_class = px_class;
   assign ifb.msg_ready = rdy_b;

   bbox_msg_engine #(.IMAGE_W(W), .IMAGE_H(H), .NUM_CLASSES(N), .CLASS_W(CW), .MSG_INTERVAL(1))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   bbox_msg_engine #(.IMAGE_W(W), .IMAGE_H(H), .NUM_CLASSES(N), .CLASS_W(CW), .MSG_INTERVAL(6))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   // Words accepted by the sink: valid & ready seen mid-cycle handshake on the next edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (ifa.msg_valid && rdy_a) qa.push_back({ifa.msg_data, ifa.msg_last});
         if (ifb.msg_valid && rdy_b) qb.push_back({ifb.msg_data, ifb.msg_last});
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic clear_img();
      for (int p = 0; p < NPIX; p++) img[p] = '0;
   endtask

   task automatic fill_rect(input int cls, input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) img[y * W + x] = CW'(cls);
   endtask

   task automatic fill_random();
      int x0, x1, y0, y1;
      clear_img();
      for (int r = 0; r < 4; r++) begin
         x0 = $urandom_range(W - 1, 0);
         x1 = $urandom_range(W - 1, x0);
         y0 = $urandom_range(H - 1, 0);
         y1 = $urandom_range(H - 1, y0);
         fill_rect($urandom_range(7, 0), x0, x1, y0, y1);
      end
      for (int s = 0; s < 10; s++) img[$urandom_range(NPIX - 1, 0)] = CW'($urandom);
   endtask

   // Reference: bounding boxes straight from the frame image, in burst order.
   function automatic void build_expected(input int npix);
      word_t w;
      exp_q.delete();
      for (int c = 1; c <= N; c++) begin
         int xmin, ymin, xmax, ymax, cnt;
         xmin = W - 1; ymin = H - 1; xmax = 0; ymax = 0; cnt = 0;
         for (int p = 0; p < npix; p++) begin
            if (int'(img[p]) == c) begin
               if (p % W < xmin) xmin = p % W;
               if (p % W > xmax) xmax = p % W;
               if (p / W < ymin) ymin = p / W;
               if (p / W > ymax) ymax = p / W;
               cnt++;
            end
         end
         w.last = 1'b0;
         w.data = {8'h42, 8'(c), 14'b0, npix != NPIX, cnt > 0};
         exp_q.push_back(w);
         w.data = {5'b0, 11'(xmin), 5'b0, 11'(ymin)};
         exp_q.push_back(w);
         w.data = {5'b0, 11'(xmax), 5'b0, 11'(ymax)};
         exp_q.push_back(w);
`ifdef BBOX_PIXCOUNT_EN
         w.data = {12'b0, 20'(cnt)};
         exp_q.push_back(w);
`endif
      end
      exp_q[exp_q.size() - 1].last = 1'b1;
   endfunction

   task automatic drive_frame(input int npix, input bit gaps);
      @(posedge clk); #1;
      px_valid = 1'b1; px_sop = 1'b1; px_eop = 1'b0; px_video = 1'b1; px_class = CW'($urandom);
      for (int p = 0; p < npix; p++) begin
         if (gaps && $urandom_range(7, 0) == 0) begin
            @(posedge clk); #1;
            px_valid = 1'b0; px_sop = 1'b0; px_class = CW'($urandom);
         end
         @(posedge clk); #1;
         px_valid = 1'b1; px_sop = 1'b0; px_eop = (p == npix - 1);
         px_video = 1'($urandom); px_class = img[p];
      end
      @(posedge clk); #1;
      px_valid = 1'b0; px_eop = 1'b0; px_class = '0;
   endtask

   task automatic drive_nonvideo();
      @(posedge clk); #1;
      px_valid = 1'b1; px_sop = 1'b1; px_eop = 1'b0; px_video = 1'b0;
      for (int p = 0; p < 24; p++) begin
         @(posedge clk); #1;
         px_sop = 1'b0; px_eop = (p == 23); px_video = 1'b1; px_class = CW'($urandom_range(5, 1));
      end
      @(posedge clk); #1;
      px_valid = 1'b0; px_eop = 1'b0; px_class = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      qa.delete(); qb.delete();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks += 4;
      if (ifa.msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", ifa.msg_valid); end
      if (ifa.msg_last !== 1'b0) begin errors++; $display("FAIL reset_last_a: got %b expected 0", ifa.msg_last); end
      if (ifa.msg_data !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h expected 0", ifa.msg_data); end
      if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun_a: got %b expected 0", ifa.overrun); end
      checks += 2;
      if (ifb.msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b expected 0", ifb.msg_valid); end
      if (ifb.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun_b: got %b expected 0", ifb.overrun); end
   endtask

   task automatic test_directed_rect();
      clear_img();
      fill_rect(2, 10, 19, 3, 6);
      rdy_a = 1'b1; qa.delete();
      drive_frame(NPIX, 1'b0);
      build_expected(NPIX);
      for (int i = 0; i < 2000 && qa.size() < BURST; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      checks++;
      if (qa.size() != BURST) begin errors++; $display("FAIL rect_len: got %0d expected %0d", qa.size(), BURST); end
      for (int i = 0; i < qa.size() && i < BURST; i++) begin
         checks++;
         if (qa[i] !== exp_q[i]) begin
            errors++; $display("FAIL rect_word%0d: got %h/%b expected %h/%b", i, qa[i].data, qa[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
      if (qa.size() == BURST) begin
         checks += 4;
         if (qa[BW].data !== 32'h42020001) begin errors++; $display("FAIL rect_hdr2: got %h expected 42020001", qa[BW].data); end
         if (qa[BW + 1].data !== 32'h000A0003) begin errors++; $display("FAIL rect_tl2: got %h expected 000a0003", qa[BW + 1].data); end
         if (qa[BW + 2].data !== 32'h00130006) begin errors++; $display("FAIL rect_br2: got %h expected 00130006", qa[BW + 2].data); end
         if (qa[1].data !== 32'h001F000F) begin errors++; $display("FAIL rect_tl1_empty: got %h expected 001f000f", qa[1].data); end
`ifdef BBOX_PIXCOUNT_EN
         checks++;
         if (qa[BW + 3].data !== 32'h00000028) begin errors++; $display("FAIL rect_cnt2: got %h expected 00000028", qa[BW + 3].data); end
`endif
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      bit          stalled;
      clear_img();
      fill_rect(2, 10, 19, 3, 6);
      rdy_a = 1'b0; qa.delete();
      drive_frame(NPIX, 1'b0);
      build_expected(NPIX);
      stalled = 1'b0; held = '0;
      for (int k = 0; k < 400 && qa.size() < BURST; k++) begin
         @(posedge clk); #1;
         rdy_a = (k % 4 == 0) || (k % 4 == 3);
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (ifa.msg_valid !== 1'b1 || ifa.msg_data !== held) begin
               errors++; $display("FAIL bp_hold: got %b/%h expected 1/%h", ifa.msg_valid, ifa.msg_data, held);
            end
         end
         stalled = ifa.msg_valid && !rdy_a;
         held = ifa.msg_data;
      end
      rdy_a = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (qa.size() != BURST) begin errors++; $display("FAIL bp_len: got %0d expected %0d", qa.size(), BURST); end
      for (int i = 0; i < qa.size() && i < BURST; i++) begin
         checks++;
         if (qa[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, qa[i].data, qa[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_frame_err();
      for (int pass = 0; pass < 2; pass++) begin
         fill_random();
         rdy_a = 1'b1; qa.delete();
         drive_frame((pass == 0) ? NPIX - 1 : NPIX, 1'b1);
         build_expected((pass == 0) ? NPIX - 1 : NPIX);
         for (int i = 0; i < 2000 && qa.size() < BURST; i++) @(negedge clk);
         repeat (10) @(negedge clk);
         checks++;
         if (qa.size() != BURST) begin errors++; $display("FAIL ferr_len%0d: got %0d expected %0d", pass, qa.size(), BURST); end
         for (int i = 0; i < qa.size() && i < BURST; i++) begin
            checks++;
            if (qa[i] !== exp_q[i]) begin
               errors++; $display("FAIL ferr%0d_word%0d: got %h/%b expected %h/%b", pass, i, qa[i].data, qa[i].last, exp_q[i].data, exp_q[i].last);
            end
            if (i % BW == 0) begin
               checks++;
               if (qa[i].data[1] !== (pass == 0)) begin
                  errors++; $display("FAIL ferr%0d_bit_cls%0d: got %b expected %b", pass, i / BW + 1, qa[i].data[1], pass == 0);
               end
            end
         end
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 4; f++) begin
         fill_random();
         rdy_a = 1'b1; qa.delete();
         drive_frame(NPIX, 1'b1);
         build_expected(NPIX);
         for (int i = 0; i < 2000 && qa.size() < BURST; i++) begin
            @(posedge clk); #1;
            rdy_a = ($urandom_range(2, 0) != 0);
         end
         rdy_a = 1'b1;
         drive_nonvideo();
         repeat (20) @(negedge clk);
         checks++;
         if (qa.size() != BURST) begin errors++; $display("FAIL rnd%0d_len: got %0d expected %0d", f, qa.size(), BURST); end
         for (int i = 0; i < qa.size() && i < BURST; i++) begin
            checks++;
            if (qa[i] !== exp_q[i]) begin
               errors++; $display("FAIL rnd%0d_word%0d: got %h/%b expected %h/%b", f, i, qa[i].data, qa[i].last, exp_q[i].data, exp_q[i].last);
            end
         end
      end
   endtask

   task automatic test_interval();
      int want;
      do_reset();
      rdy_a = 1'b1; rdy_b = 1'b1;
      for (int f = 1; f <= 12; f++) begin
         fill_random();
         drive_frame(NPIX, 1'b0);
         build_expected(NPIX);
         repeat (40) @(negedge clk);
         want = (f % 6 == 0) ? BURST : 0;
         checks++;
         if (qb.size() != want) begin errors++; $display("FAIL intv_frame%0d_len: got %0d expected %0d", f, qb.size(), want); end
         for (int i = 0; i < qb.size() && i < want; i++) begin
            checks++;
            if (qb[i] !== exp_q[i]) begin
               errors++; $display("FAIL intv%0d_word%0d: got %h/%b expected %h/%b", f, i, qb[i].data, qb[i].last, exp_q[i].data, exp_q[i].last);
            end
         end
         qa.delete(); qb.delete();
      end
   endtask

   task automatic test_overrun();
      do_reset();
      rdy_a = 1'b0;
      fill_random();
      build_expected(NPIX);
      exp1 = exp_q;
      drive_frame(NPIX, 1'b0);
      repeat (5) @(negedge clk);
      checks += 2;
      if (ifa.msg_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b expected 1", ifa.msg_valid); end
      if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", ifa.overrun); end
      fill_random();
      drive_frame(NPIX, 1'b0);
      repeat (5) @(negedge clk);
      checks += 2;
      if (ifa.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ifa.overrun); end
      if (ifa.msg_data !== exp1[0].data) begin errors++; $display("FAIL ovr_held: got %h expected %h", ifa.msg_data, exp1[0].data); end
      rdy_a = 1'b1;
      for (int i = 0; i < 2000 && qa.size() < BURST; i++) @(negedge clk);
      repeat (30) @(negedge clk);
      checks++;
      if (qa.size() != BURST) begin errors++; $display("FAIL ovr_len: got %0d expected %0d", qa.size(), BURST); end
      for (int i = 0; i < qa.size() && i < BURST; i++) begin
         checks++;
         if (qa[i] !== exp1[i]) begin
            errors++; $display("FAIL ovr_word%0d: got %h/%b expected %h/%b", i, qa[i].data, qa[i].last, exp1[i].data, exp1[i].last);
         end
      end
      checks++;
      if (ifa.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", ifa.overrun); end

      // Abort a burst part-way through with reset.
      rdy_a = 1'b0;
      fill_random();
      drive_frame(NPIX, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (ifa.msg_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got %b expected 1", ifa.msg_valid); end
      @(posedge clk); #1;
      rdy_a = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (ifa.msg_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_abort: got %b expected 0", ifa.msg_valid); end
      if (ifa.msg_last !== 1'b0) begin errors++; $display("FAIL rst_mid_last: got %b expected 0", ifa.msg_last); end
      if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b expected 0", ifa.overrun); end
      @(posedge clk); #1;
      reset = 1'b0;
      qa.delete();
      repeat (20) @(negedge clk);
      checks++;
      if (qa.size() != 0) begin errors++; $display("FAIL rst_mid_residue: got %0d expected 0", qa.size()); end
   endtask

   initial begin
      test_reset();
      test_directed_rect();
      test_backpressure();
      test_frame_err();
      test_random_frames();
      test_interval();
      test_overrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
